// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array sequencer: FSM state encoding and skew depth.
// SKEW_DEPTH is N-1 for the default array size; skew_depth() gives the same value for any N.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sa_state_e;

    localparam int SA_N_DEFAULT = 4;
    localparam int SKEW_DEPTH   = SA_N_DEFAULT - 1;

    function automatic int skew_depth(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Per-lane operand delay line of DEPTH register stages; data is forced to 0 whenever valid is low.
// flush clears every stage synchronously, rst asynchronously.
module sa_skew_line #(
    parameter int DEPTH = 0,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          d_vld,
    input  logic [DW-1:0] d_data,
    output logic          q_vld,
    output logic [DW-1:0] q_data
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst, flush};
        assign q_vld     = d_vld;
        assign q_data    = d_vld ? d_data : '0;
    end else begin : g_dly
        logic [DEPTH-1:0]         vld_p;
        logic [DEPTH-1:0][DW-1:0] data_p;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p  <= '0;
                data_p <= '0;
            end else if (flush) begin
                vld_p  <= '0;
                data_p <= '0;
            end else begin
                vld_p[0]  <= d_vld;
                data_p[0] <= d_vld ? d_data : '0;
                for (int s = 1; s < DEPTH; s++) begin
                    vld_p[s]  <= vld_p[s-1];
                    data_p[s] <= data_p[s-1];
                end
            end
        end

        assign q_vld  = vld_p[DEPTH-1];
        assign q_data = data_p[DEPTH-1];
    end

endmodule

// File: rtl/sa_seq_ctrl.sv
// Sequencer for an NxN output-stationary systolic array: clear, feed K operands, drain, done.
// Optional SA_SEQ_ABORT_EN adds an abort input that returns to IDLE and flushes the skew lines.
module sa_seq_ctrl
    import sa_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int KW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k_len,
`ifdef SA_SEQ_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          done,
    output logic          arr_clr,
    output logic          rd_en,
    output logic [KW-1:0] rd_addr,
    input  logic [N*DW-1:0] a_rdata,
    input  logic [N*DW-1:0] b_rdata,
    output logic [N*DW-1:0] a_data,
    output logic [N-1:0]    a_vld,
    output logic [N*DW-1:0] b_data,
    output logic [N-1:0]    b_vld
);

    // Drain covers west skew + north skew through the array plus the buffer read latency.
    localparam int MAX_SKEW  = skew_depth(N);
    localparam int DRAIN_LEN = 2 * MAX_SKEW + 1;
    localparam int DCW       = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

    sa_state_e      state, state_nxt;
    logic [KW-1:0]  k_lat;
    logic [KW-1:0]  cnt;
    logic [DCW-1:0] dcnt;
    logic           vld_p0;
    logic           flush;

`ifdef SA_SEQ_ABORT_EN
    assign flush = abort && (state != IDLE);
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        arr_clr   = (state == CLEAR);
        rd_en     = (state == FEED);
        rd_addr   = (state == FEED) ? cnt : '0;
        unique case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = (k_lat == '0) ? DONE : FEED;
            FEED:    if (cnt == k_lat - KW'(1)) state_nxt = DRAIN;
            DRAIN:   if (dcnt == DCW'(DRAIN_LEN - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // cnt tops out at K-1, so K = 2^KW-1 never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            k_lat  <= '0;
            cnt    <= '0;
            dcnt   <= '0;
            vld_p0 <= 1'b0;
        end else begin
            state  <= state_nxt;
            if (state == IDLE && start) k_lat <= k_len;
            cnt    <= (state == FEED && state_nxt == FEED) ? cnt + KW'(1) : '0;
            dcnt   <= (state == DRAIN && state_nxt == DRAIN) ? dcnt + DCW'(1) : '0;
            vld_p0 <= rd_en && !flush;
        end
    end

    // Lane i carries i extra stages; the deepest lane is MAX_SKEW.
    for (genvar i = 0; i < N; i++) begin : g_lane
        sa_skew_line #(.DEPTH(i), .DW(DW)) u_a_skew (
            .clk    (clk),
            .rst    (rst),
            .flush  (flush),
            .d_vld  (vld_p0),
            .d_data (a_rdata[i*DW +: DW]),
            .q_vld  (a_vld[i]),
            .q_data (a_data[i*DW +: DW])
        );
        sa_skew_line #(.DEPTH(i), .DW(DW)) u_b_skew (
            .clk    (clk),
            .rst    (rst),
            .flush  (flush),
            .d_vld  (vld_p0),
            .d_data (b_rdata[i*DW +: DW]),
            .q_vld  (b_vld[i]),
            .q_data (b_data[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl with an operand-buffer model and a 4x4 PE array model.
// Define SA_SEQ_ABORT_EN to include the abort scenario.
module tb_sa_seq_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int KW = 8;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [KW-1:0]   k_len;
    logic            busy, done, arr_clr, rd_en;
    logic [KW-1:0]   rd_addr;
    logic [N*DW-1:0] a_rdata, b_rdata, a_data, b_data;
    logic [N-1:0]    a_vld, b_vld;

    always #5 clk = ~clk;

    sa_seq_ctrl #(.N(N), .DW(DW), .KW(KW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .k_len   (k_len),
`ifdef SA_SEQ_ABORT_EN
        .abort   (abort),
`endif
        .busy    (busy),
        .done    (done),
        .arr_clr (arr_clr),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .a_rdata (a_rdata),
        .b_rdata (b_rdata),
        .a_data  (a_data),
        .a_vld   (a_vld),
        .b_data  (b_data),
        .b_vld   (b_vld)
    );

    // Operand buffers: one-cycle read latency, junk on the bus when not reading.
    logic [DW-1:0] amem [256][N];
    logic [DW-1:0] bmem [256][N];

    always @(posedge clk) begin
        for (int l = 0; l < N; l++) begin
            a_rdata[l*DW +: DW] <= rd_en ? amem[rd_addr][l] : 8'hA5;
            b_rdata[l*DW +: DW] <= rd_en ? bmem[rd_addr][l] : 8'h5A;
        end
    end

    // Output-stationary PE array: a moves east, b moves south, one register per PE.
    logic [DW-1:0] pa [N][N], pb [N][N], ain [N][N], bin [N][N];
    logic          pav [N][N], pbv [N][N], aiv [N][N], biv [N][N];
    logic [31:0]   acc [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ain[i][0] = a_data[i*DW +: DW];
            aiv[i][0] = a_vld[i];
            bin[0][i] = b_data[i*DW +: DW];
            biv[0][i] = b_vld[i];
            for (int j = 1; j < N; j++) begin
                ain[i][j] = pa[i][j-1];
                aiv[i][j] = pav[i][j-1];
                bin[j][i] = pb[j-1][i];
                biv[j][i] = pbv[j-1][i];
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (rst || arr_clr) begin
                    pa[i][j] <= '0; pb[i][j] <= '0; pav[i][j] <= 1'b0; pbv[i][j] <= 1'b0;
                    acc[i][j] <= '0;
                end else begin
                    pa[i][j] <= ain[i][j]; pav[i][j] <= aiv[i][j];
                    pb[i][j] <= bin[i][j]; pbv[i][j] <= biv[i][j];
                    if (aiv[i][j] && biv[i][j])
                        acc[i][j] <= acc[i][j] + 32'(ain[i][j]) * 32'(bin[i][j]);
                end
            end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    int t_clr, t0, t_done, n_done, n_rd, c_end;
    bit addr_ok, overlap, dirty, timeout;
    int first_a [N];
    int first_b [N];
    longint rst_ctrl_snap, rst_data_snap;
    logic [31:0] ref_acc [N][N];

    task automatic calc_ref(input int k);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ref_acc[i][j] = 0;
                for (int kk = 0; kk < k; kk++)
                    ref_acc[i][j] += 32'(amem[kk][i]) * 32'(bmem[kk][j]);
            end
    endtask

    function automatic int acc_mismatches();
        int n = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (acc[i][j] !== ref_acc[i][j]) n++;
        return n;
    endfunction

    // Cycle 1 is the cycle after the edge that accepts start (CLEAR).
    task automatic run_job(input int k, input int max_cyc, input int restart_at,
                           input int rst_at, input int abort_at);
        int c;
        bit fin;
        t_clr = -1; t0 = -1; t_done = -1; n_done = 0; n_rd = 0;
        addr_ok = 1; overlap = 0; dirty = 0; timeout = 0;
        for (int l = 0; l < N; l++) begin first_a[l] = -1; first_b[l] = -1; end
        @(negedge clk); start = 1'b1; k_len = KW'(k);
        @(negedge clk); start = 1'b0; k_len = KW'(k + 1);
        c = 1; fin = 0;
        while (!fin) begin
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                rst_ctrl_snap = longint'({busy, done, arr_clr, rd_en, rd_addr, a_vld, b_vld});
                rst_data_snap = longint'({a_data, b_data});
                fin = 1;
            end else begin
                if (arr_clr && t_clr < 0) t_clr = c;
                if (arr_clr && rd_en) overlap = 1;
                if (rd_en) begin
                    if (t0 < 0) t0 = c;
                    if (rd_addr != KW'(n_rd)) addr_ok = 0;
                    n_rd++;
                end
                if (done) begin n_done++; t_done = c; end
                for (int l = 0; l < N; l++) begin
                    if (a_vld[l] && first_a[l] < 0) first_a[l] = c;
                    if (b_vld[l] && first_b[l] < 0) first_b[l] = c;
                    if (!a_vld[l] && a_data[l*DW +: DW] != 0) dirty = 1;
                    if (!b_vld[l] && b_data[l*DW +: DW] != 0) dirty = 1;
                end
                if (!busy) fin = 1;
                else if (c >= max_cyc) begin timeout = 1; fin = 1; end
                else begin
                    start = (c == restart_at);
                    abort = (c == abort_at);
                    @(negedge clk);
                    c++;
                end
            end
        end
        c_end = c;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        int seen = 0;
        for (int q = 0; q < n; q++) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; k_len = '0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {busy, done, arr_clr, rd_en}, 0);
        chk("reset_addr", rd_addr, 0);
        chk("reset_vld", {a_vld, b_vld}, 0);
        chk("reset_data", longint'({a_data, b_data}), 0);
        rst = 1'b0;

        // A = identity, B = 1..16 row-major: accumulators must reproduce B.
        for (int k = 0; k < N; k++)
            for (int l = 0; l < N; l++) begin
                amem[k][l] = (l == k) ? 8'd1 : 8'd0;
                bmem[k][l] = DW'(4 * k + l + 1);
            end
        run_job(4, 60, -1, -1, -1);
        chk("k4_timeout", timeout, 0);
        chk("k4_clear_cycle", t_clr, 1);
        chk("k4_feed_start", t0, 2);
        chk("k4_done_cycle", t_done, 13);
        chk("k4_done_count", n_done, 1);
        chk("k4_reads", n_rd, 4);
        chk("k4_addr_seq", addr_ok, 1);
        chk("k4_clr_rd_overlap", overlap, 0);
        chk("k4_invalid_data_zero", dirty, 0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("k4_acc_%0d_%0d", i, j), acc[i][j], 4 * i + j + 1);

        // K = 0: clear then done, no reads, accumulators cleared.
        run_job(0, 20, -1, -1, -1);
        chk("k0_clear_cycle", t_clr, 1);
        chk("k0_done_cycle", t_done, 2);
        chk("k0_reads", n_rd, 0);
        chk("k0_done_count", n_done, 1);
        calc_ref(0);
        chk("k0_acc_zero", acc_mismatches(), 0);

        // K = 8 with a second start during FEED.
        for (int k = 0; k < 256; k++)
            for (int l = 0; l < N; l++) begin
                amem[k][l] = DW'((k + l) % 3);
                bmem[k][l] = DW'((k * l + 1) % 5);
            end
        run_job(8, 60, 4, -1, -1);
        chk("k8_timeout", timeout, 0);
        chk("k8_done_count", n_done, 1);
        chk("k8_reads", n_rd, 8);
        chk("k8_addr_seq", addr_ok, 1);
        chk("k8_latency", t_done - t0, 8 + 2 * N - 1);
        calc_ref(8);
        chk("k8_acc", acc_mismatches(), 0);
        quiet_cycles("k8_restart_ignored", 5);

        // Reset during the third FEED cycle of a K = 8 job.
        run_job(8, 60, -1, 4, -1);
        chk("rst_mid_ctrl", rst_ctrl_snap, 0);
        chk("rst_mid_data", rst_data_snap, 0);
        chk("rst_mid_no_done", n_done, 0);
        quiet_cycles("rst_held_quiet", 2);
        rst = 1'b0;
        quiet_cycles("rst_after_no_done", 3);
        run_job(2, 40, -1, -1, -1);
        chk("k2_done_count", n_done, 1);
        chk("k2_latency", t_done - t0, 2 + 2 * N - 1);
        calc_ref(2);
        chk("k2_acc", acc_mismatches(), 0);

        // Lane skew, K = 3.
        run_job(3, 40, -1, -1, -1);
        for (int l = 0; l < N; l++) begin
            chk($sformatf("k3_a_vld%0d_first", l), first_a[l] - t0, l + 1);
            chk($sformatf("k3_b_vld%0d_first", l), first_b[l] - t0, l + 1);
        end
        chk("k3_invalid_data_zero", dirty, 0);

        // Longest job: K = 2^KW - 1.
        for (int k = 0; k < 256; k++)
            for (int l = 0; l < N; l++) begin
                amem[k][l] = 8'd1;
                bmem[k][l] = DW'(l + 1);
            end
        run_job(255, 400, -1, -1, -1);
        chk("kmax_timeout", timeout, 0);
        chk("kmax_reads", n_rd, 255);
        chk("kmax_addr_seq", addr_ok, 1);
        chk("kmax_latency", t_done - t0, 255 + 2 * N - 1);
        chk("kmax_acc_0_0", acc[0][0], 255);
        chk("kmax_acc_3_3", acc[3][3], 1020);

`ifdef SA_SEQ_ABORT_EN
        // Abort in the second DRAIN cycle of a K = 4 job.
        run_job(4, 60, -1, -1, 7);
        chk("abort_exit_cycle", c_end, 8);
        chk("abort_busy", busy, 0);
        chk("abort_vld", {a_vld, b_vld}, 0);
        chk("abort_no_done", n_done, 0);
        quiet_cycles("abort_quiet", 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sa_seq_ctrl.md
SA_SEQ_CTRL -- requirements
Module: sa_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, meaning array dimension (rows = cols = N).
REQ-002 SHALL have parameter DW, default 8, meaning operand width.
REQ-003 SHALL have parameter KW, default 8, meaning width of k_len and of addresses.
REQ-004 clk  in  1  clock; rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  launch request; sampled in IDLE only.
REQ-007 k_len  in  KW  reduction length K; latched on accepted start.
REQ-008 busy  out  1  high whenever state != IDLE.
REQ-009 done  out  1  one-cycle pulse when all accumulators are final.
REQ-010 arr_clr  out  1  clear strobe to every PE.
REQ-011 rd_en  out  1  operand-buffer read enable (A and B).
REQ-012 rd_addr  out  KW  k index read from both buffers.
REQ-013 a_rdata  in  N*DW  A column k (lane i = row i); valid one cycle after rd_en.
REQ-014 b_rdata  in  N*DW  B row k (lane j = col j); valid one cycle after rd_en.
REQ-015 a_data / a_vld  out  N*DW / N  skewed west-edge operands and valids.
REQ-016 b_data / b_vld  out  N*DW / N  skewed north-edge operands and valids.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-018 IDLE + start SHALL go to CLEAR, latch k_len; start in any other state SHALL be ignored.
REQ-019 CLEAR SHALL last 1 cycle with arr_clr=1; next state FEED if K>0, else DONE.
REQ-020 FEED SHALL last exactly K cycles, rd_en=1, rd_addr = 0,1,...,K-1.
REQ-021 DRAIN SHALL last exactly 2N-1 cycles (skew + PE propagation + read latency), then DONE.
REQ-022 DONE SHALL last 1 cycle with done=1, then IDLE.
REQ-023 Lane i of a_data/a_vld SHALL equal a_rdata lane i / delayed rd_en after i additional register stages; b lanes identically for index j.
REQ-024 Lanes with vld=0 SHALL drive data 0.
REQ-025 With FEED first cycle t0, PE(i,j) SHALL receive operand k at cycle t0+1+k+i+j; final accumulate at end of cycle t0+K+2N-2; done at t0+K+2N-1.
REQ-026 Internal k counter SHALL be KW bits; K=2^KW-1 SHALL be supported without wrap.
REQ-027 arr_clr and rd_en SHALL never be high in the same cycle.

Reset
REQ-028 rst SHALL force IDLE and all outputs, skew registers and counters to 0 asynchronously, including mid-FEED/DRAIN; no done pulse SHALL follow.

Configuration
REQ-029 Macro SA_SEQ_ABORT_EN SHALL add input abort (1 bit).
REQ-030 With SA_SEQ_ABORT_EN: abort=1 in any non-IDLE state SHALL next cycle go IDLE, clear all skew registers/valids, suppress done; arr_clr not asserted.
REQ-031 Without SA_SEQ_ABORT_EN: no abort port; behaviour per REQ-017..027 only.

Structure
REQ-032 State encoding typedef and constant SKEW_DEPTH=N-1 SHALL live in shared package sa_pkg.
REQ-033 Per-lane delay line SHALL be sub-module sa_skew_line (parameters DEPTH, DW), instantiated 2N times.

Verification
REQ-034 N=4, K=4, A=I, B=[1..16] row-major -> done at t0+11, accumulators equal B, exactly one done pulse.
REQ-035 K=0 -> CLEAR 1 cycle, done 2 cycles after start, rd_en never high, accumulators 0.
REQ-036 start pulsed during FEED of a K=8 job -> ignored; single done; rd_addr runs 0..7 once.
REQ-037 rst asserted at FEED cycle 2 of K=8 -> all outputs 0 same cycle, no done; new start K=2 completes correctly.
REQ-038 Lane check K=3: a_vld[3] first high at t0+4, a_vld[0] at t0+1; invalid-lane data 0.
REQ-039 SA_SEQ_ABORT_EN, abort at DRAIN cycle 1 -> IDLE next cycle, all vld 0, no done, busy low.
